// File: rtl/wb_sram_pkg.sv
// Shared state type and width helpers for the line/SRAM bridge
// and the cache refill path.
`ifndef WB_IDX_W
`define WB_IDX_W(n) wb_sram_pkg::clog2(n)
`endif

package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    function automatic int be_w(input int word_w);
        return word_w / 8;
    endfunction

    function automatic int lb(input int line_words, input int word_w);
        return clog2(line_words * be_w(word_w));
    endfunction

    // Watchdog counter must hold the timeout value itself; never zero width.
    function automatic int wd_w(input int timeout);
        return (clog2(timeout + 1) < 1) ? 1 : clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/line_word_seq.sv
// Wrapping word index within a line plus a remaining-word count.
// Shared with the cache refill path.
module line_word_seq
    import wb_sram_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int IDX_W      = `WB_IDX_W(LINE_WORDS)
) (
    input  logic             clkCPU,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] i0,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] rem;

    always_ff @(posedge clkCPU) begin
        if (rst) begin
            idx <= '0;
            rem <= '0;
        end else if (start) begin
            idx <= i0;
            rem <= IDX_W'(LINE_WORDS - 1);
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
            rem <= rem - IDX_W'(1);
        end
    end

    assign last = (rem == '0);

endmodule

// File: rtl/wb_line_sram_bridge.sv
// Wishbone line slave that moves one cache line word by word to or
// from a narrow SRAM controller, critical word first.
module wb_line_sram_bridge
    import wb_sram_pkg::*;
#(
    parameter int LINE_WORDS  = 16,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NAK_TIMEOUT = 1024,
    localparam int LINE_W     = LINE_WORDS * WORD_W,
    localparam int BE_W       = be_w(WORD_W),
    localparam int DM_W       = LINE_WORDS * BE_W
) (
    input  logic              clkCPU,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ws_addr,
    input  logic [LINE_W-1:0] ws_din,
    input  logic [DM_W-1:0]   ws_dm,
    input  logic              ws_cyc,
    input  logic              ws_stb,
    input  logic              ws_we,
    output logic              ws_ack,
    output logic              ws_err,
    output logic [LINE_W-1:0] ws_dout,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [WORD_W-1:0] sramInData,
    output logic [BE_W-1:0]   sramDm,
    output logic              sramStb,
    input  logic [WORD_W-1:0] sramOutData,
    input  logic              sramNak
);

    localparam int LB     = lb(LINE_WORDS, WORD_W);
    localparam int OFF_W  = clog2(BE_W);
    localparam int IDX_W  = `WB_IDX_W(LINE_WORDS);
    localparam int BASE_W = ADDR_W - LB;
    localparam int WD_W   = wd_w(NAK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(NAK_TIMEOUT);
    localparam bit WD_EN  = (NAK_TIMEOUT != 0);

    state_e state, nstate;

    logic start, adv, last, wd_hit, word_done;
    logic [IDX_W-1:0]  idx, i0_in, w_idx;
    logic [BASE_W-1:0] base_in, base_q, w_base;
    logic              we_q, w_we;
    logic [LINE_W-1:0] din_q, shadow, shadow_nxt;
    logic [DM_W-1:0]   dm_q;
    logic [WORD_W-1:0] w_din;
    logic [BE_W-1:0]   w_dm;
    logic [WD_W-1:0]   wdog;
    logic              addr_unused;

    assign addr_unused = ^ws_addr;
    assign i0_in   = ws_addr[LB-1:OFF_W];
    assign base_in = ws_addr[ADDR_W-1:LB];

    // A skipped write word has sramStb low and retires in its one cycle.
    assign word_done = ~sramStb | ~sramNak;
    assign wd_hit    = WD_EN && (wdog == WD_MAX);

    line_word_seq #(
        .LINE_WORDS(LINE_WORDS),
        .IDX_W     (IDX_W)
    ) u_seq (
        .clkCPU (clkCPU),
        .rst    (rst),
        .start  (start),
        .i0     (i0_in),
        .advance(adv),
        .idx    (idx),
        .last   (last)
    );

    always_ff @(posedge clkCPU) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        start  = 1'b0;
        adv    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ws_cyc && ws_stb) begin
                    start  = 1'b1;
                    nstate = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!ws_cyc) begin
                    nstate = ST_IDLE;
                end else if (wd_hit) begin
                    nstate = ST_ERR;
                end else if (word_done) begin
                    adv = 1'b1;
                    if (last) nstate = ST_DONE;
                end
            end
            ST_DONE: nstate = ST_IDLE;
            ST_ERR:  nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    // Word to present next: the start word on accept, else the following one.
    assign w_idx  = start ? i0_in : idx + IDX_W'(1);
    assign w_base = start ? base_in : base_q;
    assign w_we   = start ? ws_we : we_q;
    assign w_din  = start ? ws_din[w_idx*WORD_W +: WORD_W]
                          : din_q[w_idx*WORD_W +: WORD_W];
    assign w_dm   = start ? ws_dm[w_idx*BE_W +: BE_W]
                          : dm_q[w_idx*BE_W +: BE_W];

    always_comb begin
        shadow_nxt = shadow;
        if (adv && !we_q && sramStb)
            shadow_nxt[idx*WORD_W +: WORD_W] = sramOutData;
    end

    always_ff @(posedge clkCPU) begin
        if (rst) begin
            ws_ack     <= 1'b0;
            ws_err     <= 1'b0;
            ws_dout    <= '0;
            shadow     <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            dm_q       <= '0;
            sramAddr   <= '0;
            sramInData <= '0;
            sramDm     <= '0;
            sramStb    <= 1'b0;
            wdog       <= '0;
        end else begin
            ws_ack <= adv & last;
            ws_err <= (state == ST_XFER) && (nstate == ST_ERR);
            shadow <= shadow_nxt;
            // The whole line becomes visible at once, together with ack.
            if (adv && last && !we_q) ws_dout <= shadow_nxt;
            if (start) begin
                base_q <= base_in;
                we_q   <= ws_we;
                din_q  <= ws_din;
                dm_q   <= ws_dm;
            end
            if (start || (adv && !last)) begin
                sramAddr   <= ADDR_W'({w_base, w_idx}) << OFF_W;
                sramInData <= w_we ? w_din : '0;
                sramDm     <= w_we ? w_dm : '0;
                sramStb    <= ~w_we | (|w_dm);
            end else if (nstate != ST_XFER) begin
                sramStb <= 1'b0;
                sramDm  <= '0;
            end
            if (start || adv || nstate != ST_XFER) wdog <= '0;
            else if (sramStb && sramNak)           wdog <= wdog + WD_W'(1);
        end
    end

endmodule
